// File: rtl/cpu_pkg.sv
// Shared CPU definitions: mul/div op codes, mul/div FSM states and the
// conditional-negate helper used for sign fixup.
package cpu_pkg;
  localparam int XLEN = 32;

  localparam logic [1:0] MD_MULT  = 2'd0;
  localparam logic [1:0] MD_MULTU = 2'd1;
  localparam logic [1:0] MD_DIV   = 2'd2;
  localparam logic [1:0] MD_DIVU  = 2'd3;

  typedef enum logic [1:0] {
    MD_IDLE,
    MD_CALC,
    MD_SIGN,
    MD_DONE
  } md_state_t;

  function automatic logic [2*XLEN-1:0] cond_neg(input logic [2*XLEN-1:0] value, input logic en);
    return en ? -value : value;
  endfunction
endpackage

// File: rtl/ex_muldiv_if.sv
// Operand/result bundle between the ID/EX register, the hazard unit and the
// EX-stage multiply/divide unit.
interface ex_muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             flush;
  logic             stall_req;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, op_a, op_b, flush,
    input  stall_req, busy, done, div_zero, hi, lo
  );

  modport slave (
    input  start, op, op_a, op_b, flush,
    output stall_req, busy, done, div_zero, hi, lo
  );
endinterface

// File: rtl/ex_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit: one shift-add or restoring-divide step
// per cycle on magnitudes, then a single sign-fixup cycle that writes HI/LO.
module ex_muldiv
  import cpu_pkg::*;
#(
  parameter int WIDTH = XLEN
) (
  input  logic        clk,
  input  logic        rst,
  ex_muldiv_if.slave  md
);
  localparam int CNT_W = $clog2(WIDTH) + 1;

  md_state_t          state, state_nxt;
  logic [CNT_W-1:0]   count;
  logic [1:0]         op_r;
  logic [WIDTH-1:0]   mag_b, raw_a;
  logic               neg_q, neg_r, b_zero;
  logic [2*WIDTH-1:0] acc, acc_nxt;
  logic [WIDTH:0]     add_sum, rem_sh, trial;
  logic [2*XLEN-1:0]  prod_fix, quo_fix, rem_fix;
  logic [WIDTH-1:0]   hi_nxt, lo_nxt;
  logic               is_div, sgn_in, accept;
  logic               fix_unused;

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic sgn);
    return (sgn && v[WIDTH-1]) ? -v : v;
  endfunction

  assign is_div        = (op_r == MD_DIV) || (op_r == MD_DIVU);
  assign sgn_in        = (md.op == MD_MULT) || (md.op == MD_DIV);
  assign accept        = (state == MD_IDLE) && md.start && !md.flush;
  assign md.stall_req  = md.start && (state != MD_DONE) && !md.flush;

  always_comb begin
    state_nxt = state;
    unique case (state)
      MD_IDLE: if (accept) state_nxt = MD_CALC;
      MD_CALC: begin
        if (md.flush)                           state_nxt = MD_IDLE;
        else if (count == CNT_W'(WIDTH - 1))    state_nxt = MD_SIGN;
      end
      MD_SIGN: state_nxt = md.flush ? MD_IDLE : MD_DONE;
      MD_DONE: state_nxt = MD_IDLE;
      default: state_nxt = MD_IDLE;
    endcase
  end

  // Multiply keeps {partial product, multiplier}; divide keeps {remainder, dividend/quotient}.
  always_comb begin
    add_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mag_b} : '0);
    rem_sh  = acc[2*WIDTH-1:WIDTH-1];
    trial   = rem_sh - {1'b0, mag_b};
    if (!is_div)
      acc_nxt = {add_sum, acc[WIDTH-1:1]};
    else if (!trial[WIDTH])
      acc_nxt = {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    else
      acc_nxt = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
  end

  always_comb begin
    prod_fix = cond_neg((2*XLEN)'(acc), neg_q);
    quo_fix  = cond_neg((2*XLEN)'(acc[WIDTH-1:0]), neg_q);
    rem_fix  = cond_neg((2*XLEN)'(acc[2*WIDTH-1:WIDTH]), neg_r);
    if (!is_div) begin
      {hi_nxt, lo_nxt} = prod_fix[2*WIDTH-1:0];
    end else if (b_zero) begin
      lo_nxt = '1;
      hi_nxt = raw_a;
    end else begin
      lo_nxt = quo_fix[WIDTH-1:0];
      hi_nxt = rem_fix[WIDTH-1:0];
    end
  end

  assign fix_unused = ^{quo_fix[2*XLEN-1:WIDTH], rem_fix[2*XLEN-1:WIDTH]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= MD_IDLE;
      count       <= '0;
      md.hi       <= '0;
      md.lo       <= '0;
      md.done     <= 1'b0;
      md.div_zero <= 1'b0;
      md.busy     <= 1'b0;
    end else begin
      state   <= state_nxt;
      md.busy <= (state_nxt == MD_CALC) || (state_nxt == MD_SIGN);
      md.done <= (state_nxt == MD_DONE);
      if (accept) begin
        count       <= '0;
        md.div_zero <= 1'b0;
      end else if (state == MD_CALC) begin
        count <= count + CNT_W'(1);
      end
      if (state == MD_SIGN && state_nxt == MD_DONE) begin
        md.hi       <= hi_nxt;
        md.lo       <= lo_nxt;
        md.div_zero <= is_div && b_zero;
      end
    end
  end

  // Operand capture and iteration datapath; control alone decides when it matters.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_r   <= md.op;
      acc    <= {{WIDTH{1'b0}}, magnitude(md.op_a, sgn_in)};
      mag_b  <= magnitude(md.op_b, sgn_in);
      raw_a  <= md.op_a;
      b_zero <= (md.op_b == '0);
      neg_q  <= sgn_in && (md.op_a[WIDTH-1] ^ md.op_b[WIDTH-1]);
      neg_r  <= sgn_in && md.op[1] && md.op_a[WIDTH-1];
    end else if (state == MD_CALC) begin
      acc <= acc_nxt;
    end
  end
endmodule

// File: doc/ex_muldiv.md
# ex_muldiv

Iterative multiply/divide unit in the EX stage, directly downstream of the ID/EX pipeline register. It consumes the operands and decoded MULT/MULTU/DIV/DIVU operation that the ID/EX register presents, and holds the pipeline via `stall_req` while it computes. Results go to the architectural HI/LO registers, which the EX result mux reads for MFHI/MFLO.

## Interface
- `WIDTH`, default 32: operand width; iteration count equals `WIDTH`.
- `clk` input, 1 bit: single clock, rising edge.
- `rst` input, 1 bit: synchronous, active-high reset.
- `start` input, 1 bit: ID/EX holds a mul/div instruction.
- `op` input, 2 bits: operation select; 0=MULT, 1=MULTU, 2=DIV, 3=DIVU.
- `op_a` input, `WIDTH` bits: rs value, already forwarded.
- `op_b` input, `WIDTH` bits: rt value, already forwarded.
- `flush` input, 1 bit: abort any in-flight operation (branch mispredict or ID/EX flush).
- `stall_req` output, 1 bit: combinational; hazard unit deasserts the PC, IF/ID and ID/EX write enables while this is high.
- `busy` output, 1 bit: registered; high in CALC and SIGN.
- `done` output, 1 bit: registered; one-cycle pulse when HI/LO are updated.
- `div_zero` output, 1 bit: registered; set at DONE for a divide with `op_b`=0, cleared at the next accepted start.
- `hi` output, `WIDTH` bits: HI register.
- `lo` output, `WIDTH` bits: LO register.

## Operation
States are IDLE, CALC, SIGN and DONE.

**IDLE**
- If `start` is high and `flush` is low, latch `op`, the magnitudes of `op_a`/`op_b`, and the result signs, then go to CALC with `count`=0.
- The magnitude is the absolute value for signed ops and the raw value for unsigned ops.

**CALC**
- One iteration per cycle; `count` increments. After iteration `WIDTH`-1, go to SIGN.
- Multiply: shift-add on a 2×`WIDTH` accumulator, unsigned magnitudes.
- Divide: restoring division on unsigned magnitudes. The quotient bit is 1 when the trial remainder is ≥0.

**SIGN**
- Multiply: negate the 64-bit product when sign(a)^sign(b) for MULT.
- DIV: negate the quotient when sign(a)^sign(b); negate the remainder when sign(a).
- Write `hi`/`lo` (multiply: hi=upper, lo=lower; divide: lo=quotient, hi=remainder), then go to DONE.
- Divisor zero: skip sign fixup; lo=all ones, hi=`op_a` raw; set `div_zero`.
- −2^31 / −1 gives lo=0x8000_0000, hi=0. No trap.

**DONE**
- `done`=1 and `start` is ignored. Go to IDLE next cycle.

**stall_req**
- `stall_req` = `start` & (state≠DONE) & ~`flush`.
- The stalled ID/EX register keeps `start` high through CALC/SIGN.
- In DONE the stall drops, so the instruction advances. A new start is accepted in the following IDLE cycle.

**flush**
- In any state, `flush` forces IDLE next cycle.
- `hi`/`lo`/`div_zero` are unchanged and `done` is not asserted.
- `flush` in SIGN wins: HI/LO are not written.

**start deassert**
- `start` falling without `flush` during CALC/SIGN does not abort; the operation completes.

**rst**
- Overrides everything, including mid-operation.
- State=IDLE, `count`=0, `hi`=`lo`=0, `done`=0, `div_zero`=0, `busy`=0.

## Timing
- `start` sampled at edge N: CALC for edges N+1..N+32, SIGN at edge N+33 (HI/LO written), DONE during cycle N+34.
- `done` is high for exactly that one cycle, with HI/LO already valid.
- Latency is 34 cycles from the start edge to the `done` cycle.
- `stall_req` is high from the cycle `start` first appears through the last SIGN cycle: 34 stall cycles.
- Back-to-back ops: the second start is accepted one cycle after DONE, at the earliest edge N+35.
- `hi`/`lo` change only on the SIGN→DONE edge or `rst`.

## Structure
- Shared package `cpu_pkg`:
  - op codes `MD_MULT`, `MD_MULTU`, `MD_DIV`, `MD_DIVU` (2 bits)
  - state enum `md_state_t`
  - `XLEN`=32
- Single module, no sub-module. The conditional-negate helper is a package function `cond_neg(value, en)`.
- Counter width is $clog2(`WIDTH`)+1.

## Test plan
- MULTU 0xFFFF_FFFF × 0xFFFF_FFFF → hi=0xFFFF_FFFE, lo=0x0000_0001; `done` exactly 34 cycles after the start edge; `stall_req` high for 34 cycles.
- MULT −3 × 7 → hi=0xFFFF_FFFF, lo=0xFFFF_FFEB. MULT 0x8000_0000 × 0x8000_0000 → hi=0x4000_0000, lo=0.
- DIV −7 / 2 → lo=0xFFFF_FFFD, hi=0xFFFF_FFFF. DIVU 100 / 7 → lo=14, hi=2. DIV 0x8000_0000 / −1 → lo=0x8000_0000, hi=0.
- DIV 5 / 0 → lo=0xFFFF_FFFF, hi=5, `div_zero`=1. The next DIVU 9 / 3 clears `div_zero`; lo=3, hi=0.
- Flush cases:
  - Preload hi=lo=0x1234, start MULTU, assert `flush` at CALC cycle 10 → IDLE next cycle, `busy`=0, no `done`, hi=lo=0x1234.
  - Repeat with `flush` in SIGN → same result.
- Reset and back-to-back:
  - `rst` at cycle 20 of a DIV → all outputs 0 next cycle.
  - Two back-to-back MULTUs with `start` held → second accepted one cycle after the first `done`, with no lost or duplicated result.
